// File: rtl/cmult_arbiter_if.sv
// Two-client request/result bus plus the shared complex-multiplier port.
// The arbiter takes the slave side; clients and the multiplier stub take master.
interface cmult_arbiter_if;
   localparam int unsigned OP_W  = 16;
   localparam int unsigned RES_W = 32;

   logic                    req0_valid;
   logic                    req0_ready;
   logic signed [OP_W-1:0]  req0_a_i;
   logic signed [OP_W-1:0]  req0_a_q;
   logic signed [OP_W-1:0]  req0_b_i;
   logic signed [OP_W-1:0]  req0_b_q;
   logic                    req1_valid;
   logic                    req1_ready;
   logic signed [OP_W-1:0]  req1_a_i;
   logic signed [OP_W-1:0]  req1_a_q;
   logic signed [OP_W-1:0]  req1_b_i;
   logic signed [OP_W-1:0]  req1_b_q;

   logic signed [RES_W-1:0] res0_i;
   logic signed [RES_W-1:0] res0_q;
   logic                    res0_strobe;
   logic signed [RES_W-1:0] res1_i;
   logic signed [RES_W-1:0] res1_q;
   logic                    res1_strobe;

   logic signed [OP_W-1:0]  m_a_i;
   logic signed [OP_W-1:0]  m_a_q;
   logic signed [OP_W-1:0]  m_b_i;
   logic signed [OP_W-1:0]  m_b_q;
   logic                    m_input_strobe;
   logic signed [RES_W-1:0] m_p_i;
   logic signed [RES_W-1:0] m_p_q;
   logic                    m_output_strobe;

   modport slave (
      input  req0_valid, req0_a_i, req0_a_q, req0_b_i, req0_b_q,
      input  req1_valid, req1_a_i, req1_a_q, req1_b_i, req1_b_q,
      output req0_ready, req1_ready,
      output res0_i, res0_q, res0_strobe, res1_i, res1_q, res1_strobe,
      output m_a_i, m_a_q, m_b_i, m_b_q, m_input_strobe,
      input  m_p_i, m_p_q, m_output_strobe
   );

   modport master (
      output req0_valid, req0_a_i, req0_a_q, req0_b_i, req0_b_q,
      output req1_valid, req1_a_i, req1_a_q, req1_b_i, req1_b_q,
      input  req0_ready, req1_ready,
      input  res0_i, res0_q, res0_strobe, res1_i, res1_q, res1_strobe,
      input  m_a_i, m_a_q, m_b_i, m_b_q, m_input_strobe,
      output m_p_i, m_p_q, m_output_strobe
   );
endinterface

// File: rtl/cmult_arbiter.sv
// Round-robin arbiter sharing one complex multiplier between two clients; a tag
// FIFO remembers the issuing client so results route back in issue order.
module cmult_arbiter #(
   parameter int unsigned TAG_DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   cmult_arbiter_if.slave             bus,
   output logic [$clog2(TAG_DEPTH):0] inflight,
   output logic                       err
);
   localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic             last_grant;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             tag_mem [TAG_DEPTH];

   logic grant_ok_c;
   logic gnt0_c;
   logic gnt1_c;
   logic push_c;
   logic win_c;
   logic pop_c;
   logic spurious_c;
   logic pop_tag_c;

   // No grants while full; the tag FIFO is sized to the in-flight limit.
   assign grant_ok_c = enable && !reset && (inflight < CNT_W'(TAG_DEPTH));

   // Contention goes to the client that did not win last.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (grant_ok_c) begin
         if (bus.req0_valid && bus.req1_valid) begin
            gnt0_c = last_grant;
            gnt1_c = !last_grant;
         end else begin
            gnt0_c = bus.req0_valid;
            gnt1_c = bus.req1_valid;
         end
      end
   end

   assign bus.req0_ready = gnt0_c;
   assign bus.req1_ready = gnt1_c;
   assign push_c         = gnt0_c || gnt1_c;
   assign win_c          = gnt1_c;
   assign pop_c          = bus.m_output_strobe && (inflight != '0);
   assign spurious_c     = bus.m_output_strobe && (inflight == '0);
   assign pop_tag_c      = tag_mem[rd_ptr];

   // Issue side: operand register, issue pulse, round-robin pointer, write pointer.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.m_a_i          <= '0;
         bus.m_a_q          <= '0;
         bus.m_b_i          <= '0;
         bus.m_b_q          <= '0;
         bus.m_input_strobe <= 1'b0;
         last_grant         <= 1'b1;
         wr_ptr             <= '0;
      end else begin
         bus.m_input_strobe <= push_c;
         if (push_c) begin
            bus.m_a_i  <= win_c ? bus.req1_a_i : bus.req0_a_i;
            bus.m_a_q  <= win_c ? bus.req1_a_q : bus.req0_a_q;
            bus.m_b_i  <= win_c ? bus.req1_b_i : bus.req0_b_i;
            bus.m_b_q  <= win_c ? bus.req1_b_q : bus.req0_b_q;
            last_grant <= win_c;
            wr_ptr     <= wr_ptr + PTR_W'(1);
         end
      end
   end

   // Tag storage needs no reset: entries are only read behind the write pointer.
   always_ff @(posedge clock) begin
      if (push_c) begin
         tag_mem[wr_ptr] <= win_c;
      end
   end

   // Return side: route the product by head tag; strobes with no tag are dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.res0_i      <= '0;
         bus.res0_q      <= '0;
         bus.res0_strobe <= 1'b0;
         bus.res1_i      <= '0;
         bus.res1_q      <= '0;
         bus.res1_strobe <= 1'b0;
         rd_ptr          <= '0;
         err             <= 1'b0;
      end else begin
         bus.res0_strobe <= pop_c && !pop_tag_c;
         bus.res1_strobe <= pop_c && pop_tag_c;
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            if (pop_tag_c) begin
               bus.res1_i <= bus.m_p_i;
               bus.res1_q <= bus.m_p_q;
            end else begin
               bus.res0_i <= bus.m_p_i;
               bus.res0_q <= bus.m_p_q;
            end
         end
         if (spurious_c) begin
            err <= 1'b1;
         end
      end
   end

   // Occupancy: simultaneous push and pop cancel.
   always_ff @(posedge clock) begin
      if (reset) begin
         inflight <= '0;
      end else if (push_c && !pop_c) begin
         inflight <= inflight + CNT_W'(1);
      end else if (pop_c && !push_c) begin
         inflight <= inflight - CNT_W'(1);
      end
   end
endmodule
